// File: rtl/wb_pkg.sv
// wb_pkg: shared constants and the queued-write entry type for the writeback
// arbiter. Imported by wb_queue and wb_write_arbiter.
//   QDEPTH       - auxiliary write queue depth
//   STARVE_LIMIT - consecutive starved cycles before a writeback bubble is requested
//   PC_REG       - register index that aliases the program counter
package wb_pkg;

  localparam int QDEPTH       = 4;
  localparam int STARVE_LIMIT = 8;
  localparam logic [3:0] PC_REG = 4'hF;

  // Occupancy counter width (0..QDEPTH) and slot index width.
  localparam int CW = $clog2(QDEPTH + 1);
  localparam int IW = $clog2(QDEPTH);
  // Starvation counter only needs to reach STARVE_LIMIT-1.
  localparam int SW = $clog2(STARVE_LIMIT);

  typedef struct packed {
    logic [3:0]  wa;
    logic [31:0] wd;
    logic        live;   // cleared when a younger primary write supersedes it
  } wb_entry_t;

endpackage

// File: rtl/wb_queue.sv
// wb_queue: in-order queue of auxiliary register writes with kill/match logic.
// Slot 0 is always the head; a pop shifts the remaining entries down.
// Optional forwarding lookup when WB_FWD_EN is defined.
// Ports:
//   clk, reset                   - clock, synchronous active-high reset
//   push_i, push_wa_i, push_wd_i - enqueue (caller guarantees space)
//   pop_i                        - drop the head entry
//   kill_i, kill_wa_i            - clear live on queued entries targeting kill_wa_i
//   count_o                      - registered occupancy
//   head_wa_o/wd_o/live_o        - head entry contents
//   fwd_ra*_i, fwd_hit*_o, fwd_rd*_o - youngest live match lookup (WB_FWD_EN)
//   pending_o                    - per-register live-write flags, r0..r14
module wb_queue
  import wb_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          push_i,
  input  logic [3:0]    push_wa_i,
  input  logic [31:0]   push_wd_i,
  input  logic          pop_i,
  input  logic          kill_i,
  input  logic [3:0]    kill_wa_i,
  output logic [CW-1:0] count_o,
  output logic [3:0]    head_wa_o,
  output logic [31:0]   head_wd_o,
  output logic          head_live_o,
`ifdef WB_FWD_EN
  input  logic [3:0]    fwd_ra1_i,
  input  logic [3:0]    fwd_ra2_i,
  output logic          fwd_hit1_o,
  output logic          fwd_hit2_o,
  output logic [31:0]   fwd_rd1_o,
  output logic [31:0]   fwd_rd2_o,
`endif
  output logic [14:0]   pending_o
);

  wb_entry_t         ent_q [QDEPTH];
  wb_entry_t         ent_d [QDEPTH];
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [QDEPTH-1:0] vld;

  always_comb begin
    for (int i = 0; i < QDEPTH; i++) vld[i] = (i < int'(cnt_q));
  end

  // Kill first, then pop, then push: a same-edge enqueue lands after the
  // kill, so the aux result (the younger write) stays live.
  always_comb begin
    ent_d = ent_q;
    cnt_d = cnt_q;
    for (int i = 0; i < QDEPTH; i++)
      if (kill_i && vld[i] && ent_q[i].wa == kill_wa_i) ent_d[i].live = 1'b0;
    if (pop_i && cnt_q != '0) begin
      for (int i = 0; i < QDEPTH - 1; i++) ent_d[i] = ent_d[i+1];
      ent_d[QDEPTH-1] = '0;
      cnt_d = cnt_q - 1'b1;
    end
    if (push_i && cnt_d < CW'(QDEPTH)) begin
      ent_d[cnt_d[IW-1:0]] = '{wa: push_wa_i, wd: push_wd_i, live: 1'b1};
      cnt_d = cnt_d + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      for (int i = 0; i < QDEPTH; i++) ent_q[i] <= '0;
    end else begin
      cnt_q <= cnt_d;
      ent_q <= ent_d;
    end
  end

  assign count_o     = cnt_q;
  assign head_wa_o   = ent_q[0].wa;
  assign head_wd_o   = ent_q[0].wd;
  assign head_live_o = ent_q[0].live;

  // Built from queue state only; the PC alias never shows as pending.
  always_comb begin
    pending_o = '0;
    for (int n = 0; n < 15; n++)
      for (int i = 0; i < QDEPTH; i++)
        if (vld[i] && ent_q[i].live && ent_q[i].wa == 4'(n)) pending_o[n] = 1'b1;
  end

`ifdef WB_FWD_EN
  // Ascending scan so the youngest (highest slot) match wins.
  always_comb begin
    fwd_hit1_o = 1'b0;
    fwd_rd1_o  = '0;
    fwd_hit2_o = 1'b0;
    fwd_rd2_o  = '0;
    for (int i = 0; i < QDEPTH; i++) begin
      if (vld[i] && ent_q[i].live) begin
        if (ent_q[i].wa == fwd_ra1_i && fwd_ra1_i != PC_REG) begin
          fwd_hit1_o = 1'b1;
          fwd_rd1_o  = ent_q[i].wd;
        end
        if (ent_q[i].wa == fwd_ra2_i && fwd_ra2_i != PC_REG) begin
          fwd_hit2_o = 1'b1;
          fwd_rd2_o  = ent_q[i].wd;
        end
      end
    end
  end
`endif

endmodule

// File: rtl/wb_write_arbiter.sv
// wb_write_arbiter: merges the pipeline writeback port with a queue of
// auxiliary (mul/load) results onto a single register-file write port.
// Primary writes win; the queue drains when the primary port is idle.
// Writes to register 15 are redirected to the PC write port.
// Optional macro WB_FWD_EN adds a forwarding lookup into the queue.
// Ports:
//   clk, reset                      - clock, synchronous active-high reset
//   wb_we, wb_wa, wb_wd             - primary writeback request
//   aux_valid/ready, aux_wa, aux_wd - auxiliary producer handshake
//   we3, wa3, wd3                   - registered register-file write
//   pc_we, pc_wd                    - registered PC write
//   fwd_ra*, fwd_hit*, fwd_rd*      - queue forwarding (WB_FWD_EN only)
//   pending                         - r0..r14 have a live queued write
//   wb_stall                        - one-cycle bubble request after starvation
module wb_write_arbiter
  import wb_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_we,
  input  logic [3:0]  wb_wa,
  input  logic [31:0] wb_wd,
  input  logic        aux_valid,
  output logic        aux_ready,
  input  logic [3:0]  aux_wa,
  input  logic [31:0] aux_wd,
  output logic        we3,
  output logic [3:0]  wa3,
  output logic [31:0] wd3,
  output logic        pc_we,
  output logic [31:0] pc_wd,
  output logic [14:0] pending,
`ifdef WB_FWD_EN
  input  logic [3:0]  fwd_ra1,
  input  logic [3:0]  fwd_ra2,
  output logic        fwd_hit1,
  output logic        fwd_hit2,
  output logic [31:0] fwd_rd1,
  output logic [31:0] fwd_rd2,
`endif
  output logic        wb_stall
);

  logic [CW-1:0] q_cnt;
  logic [3:0]    head_wa;
  logic [31:0]   head_wd;
  logic          head_live;
  logic          nonempty, push, pop;
  logic          sel_vld;
  logic [3:0]    sel_wa;
  logic [31:0]   sel_wd;
  logic          we3_q, pc_we_q, stall_q, stall_d;
  logic [3:0]    wa3_q;
  logic [31:0]   wd3_q, pc_wd_q;
  logic [SW-1:0] scnt_q, scnt_d;

  // Ready depends only on the registered count, so a full queue stays
  // not-ready even in a cycle where the head drains.
  assign nonempty  = (q_cnt != '0);
  assign aux_ready = (q_cnt < CW'(QDEPTH));
  assign push      = aux_valid && aux_ready;
  assign pop       = !wb_we && nonempty;

  wb_queue u_queue (
    .clk         (clk),
    .reset       (reset),
    .push_i      (push),
    .push_wa_i   (aux_wa),
    .push_wd_i   (aux_wd),
    .pop_i       (pop),
    .kill_i      (wb_we),
    .kill_wa_i   (wb_wa),
    .count_o     (q_cnt),
    .head_wa_o   (head_wa),
    .head_wd_o   (head_wd),
    .head_live_o (head_live),
`ifdef WB_FWD_EN
    .fwd_ra1_i   (fwd_ra1),
    .fwd_ra2_i   (fwd_ra2),
    .fwd_hit1_o  (fwd_hit1),
    .fwd_hit2_o  (fwd_hit2),
    .fwd_rd1_o   (fwd_rd1),
    .fwd_rd2_o   (fwd_rd2),
`endif
    .pending_o   (pending)
  );

  // A killed head still takes its drain slot but issues nothing.
  always_comb begin
    sel_vld = 1'b0;
    sel_wa  = wb_wa;
    sel_wd  = wb_wd;
    if (wb_we) begin
      sel_vld = 1'b1;
    end else if (pop) begin
      sel_vld = head_live;
      sel_wa  = head_wa;
      sel_wd  = head_wd;
    end
  end

  // Counts consecutive edges where the queue was starved by the primary port.
  // The stall cycle itself always restarts the count.
  always_comb begin
    stall_d = 1'b0;
    scnt_d  = '0;
    if (!stall_q && nonempty && wb_we) begin
      if (scnt_q == SW'(STARVE_LIMIT - 1)) stall_d = 1'b1;
      else                                  scnt_d  = scnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      we3_q   <= 1'b0;
      wa3_q   <= '0;
      wd3_q   <= '0;
      pc_we_q <= 1'b0;
      pc_wd_q <= '0;
      scnt_q  <= '0;
      stall_q <= 1'b0;
    end else begin
      we3_q   <= sel_vld && (sel_wa != PC_REG);
      pc_we_q <= sel_vld && (sel_wa == PC_REG);
      if (sel_vld && sel_wa != PC_REG) begin
        wa3_q <= sel_wa;
        wd3_q <= sel_wd;
      end
      if (sel_vld && sel_wa == PC_REG) pc_wd_q <= sel_wd;
      scnt_q  <= scnt_d;
      stall_q <= stall_d;
    end
  end

  assign we3      = we3_q;
  assign wa3      = wa3_q;
  assign wd3      = wd3_q;
  assign pc_we    = pc_we_q;
  assign pc_wd    = pc_wd_q;
  assign wb_stall = stall_q;

endmodule

// File: doc/wb_write_arbiter.md
WB_WRITE_ARBITER -- requirements
Module: wb_write_arbiter

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset: clk input 1 (rising edge samples all state); reset input 1 (synchronous, active-high).
REQ-002 Pipeline writeback ports SHALL be: wb_we input 1 (primary write request); wb_wa input 4 (destination register); wb_wd input 32 (write data).
REQ-003 Auxiliary producer ports (multi-cycle mul/load) SHALL be: aux_valid input 1; aux_ready output 1; aux_wa input 4; aux_wd input 32.
REQ-004 Register-file write port SHALL be: we3 output 1; wa3 output 4; wd3 output 32.
REQ-005 PC write port SHALL be: pc_we output 1; pc_wd output 32.
REQ-006 Hazard ports SHALL be: pending output 15 (bit n set = register n has a queued write); wb_stall output 1 (request one-cycle writeback bubble).

Function
REQ-007 Aux handshake SHALL be valid/ready: an entry is enqueued on a rising edge with aux_valid && aux_ready; aux_ready = (queue count < QDEPTH), with no same-cycle pass-through.
REQ-008 The queue SHALL be in-order with QDEPTH = 4 entries; each entry holds {wa, wd, live}.
REQ-009 Arbitration: with wb_we=1 the primary write SHALL win; otherwise the queue head SHALL drain (one entry per cycle).
REQ-010 Latency: the winning write SHALL appear on we3/wa3/wd3 (or pc_we/pc_wd) registered, one cycle after acceptance.
REQ-011 Destination 15 SHALL never assert we3; it SHALL assert pc_we with pc_wd for one cycle instead.
REQ-012 Kill rule: a primary write to register R SHALL clear live on every queued entry with wa==R in the same edge; killed entries drain silently (no we3/pc_we, one cycle each).
REQ-013 An entry enqueued in the same cycle as a primary write to the same register SHALL be kept live (the aux result is the younger write).
REQ-014 pending[n] SHALL equal the OR of live entries with wa==n, registered; register 15 is excluded.
REQ-015 A starvation counter SHALL count consecutive cycles with queue non-empty and wb_we=1; at STARVE_LIMIT = 8 it SHALL assert wb_stall for exactly one cycle, then clear.
REQ-016 Upstream SHALL keep wb_we=0 while wb_stall=1; if wb_we=1 anyway, the primary still wins and the counter restarts.
REQ-017 Full queue with simultaneous drain: aux_ready SHALL stay 0 that cycle (reflects registered count).

Reset
REQ-018 On reset: queue empty, all live=0, counter=0; we3=0, wa3=0, wd3=0, pc_we=0, pc_wd=0, pending=0, wb_stall=0, aux_ready=1 the cycle after reset deasserts.
REQ-019 Reset mid-operation SHALL discard all queued entries without issuing any write.

Configuration
REQ-020 Macro WB_FWD_EN: when defined, add ports fwd_ra1/fwd_ra2 input 4 and fwd_hit1/fwd_hit2 output 1, fwd_rd1/fwd_rd2 output 32, returning combinationally the youngest live queued entry matching the address (hit=0, data=0 for address 15 or no match).
REQ-021 Without WB_FWD_EN those ports SHALL be absent and behaviour is otherwise identical.

Structure
REQ-022 Package wb_pkg SHALL hold QDEPTH, STARVE_LIMIT, PC_REG = 4'hF and the queue-entry type.
REQ-023 The FIFO with kill/match logic SHALL be sub-module wb_queue; arbitration, counter and output registers stay in wb_write_arbiter.

Verification
REQ-024 Aux only: enqueue (R3, 0x11111111) with wb_we=0 -> next cycle we3=1, wa3=3, wd3=0x11111111; pending[3] high for exactly that interval.
REQ-025 Kill: enqueue (R5, 0xAAAA0000), next cycle wb_we with R5=0xBBBB0000 -> only 0xBBBB0000 written to R5; queued entry drains with we3=0; pending[5] clears.
REQ-026 Full: 4 enqueues while wb_we=1 continuously -> aux_ready=0 after the 4th; wb_stall pulses on the 8th consecutive cycle; with wb_we=0 during the stall, head drains.
REQ-027 PC: aux write to R15 data 0x00000100 -> pc_we=1, pc_wd=0x00000100, we3=0, pending unchanged.
REQ-028 Reset with 3 entries queued -> no we3/pc_we afterwards; pending=0; aux_ready=1.
REQ-029 WB_FWD_EN: two queued entries to R7 (0x1, then 0x2), fwd_ra1=7 -> fwd_hit1=1, fwd_rd1=0x2; fwd_ra2=15 -> fwd_hit2=0.
